// File: rtl/pcm_record_buffer_if.sv
// rtl/pcm_record_buffer_if.sv - codec-side stream bundle for the record/replay buffer
//
// Purpose: groups the AC97 codec-facing signals of pcm_record_buffer.
//   record_valid  one-cycle pulse per captured frame (PCM_Record_Valid)
//   record_left   captured left sample, two's complement (PCM_Record_Left)
//   record_right  captured right sample, two's complement (PCM_Record_Right)
//   new_frame     one-cycle pulse per playback frame (PCM_Playback_Accept)
//   sample_left   playback left sample towards the codec
//   sample_right  playback right sample towards the codec
// Modports:
//   master  codec side: drives record_* and new_frame, receives sample_*
//   slave   buffer side: receives record_* and new_frame, drives sample_*

interface pcm_record_buffer_if;
    logic        record_valid;
    logic [15:0] record_left;
    logic [15:0] record_right;
    logic        new_frame;
    logic [15:0] sample_left;
    logic [15:0] sample_right;

    modport master (
        output record_valid,
        output record_left,
        output record_right,
        output new_frame,
        input  sample_left,
        input  sample_right
    );

    modport slave (
        input  record_valid,
        input  record_left,
        input  record_right,
        input  new_frame,
        output sample_left,
        output sample_right
    );
endinterface

// File: rtl/pcm_record_buffer.sv
// rtl/pcm_record_buffer.sv - capture-and-replay stereo PCM buffer for an AC97 codec
//
// Purpose: records stereo frames from the codec record path into a RAM and
// replays them one frame per playback-accept pulse.
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   record_button  single-cycle pulse, starts/stops recording
//   play_button    single-cycle pulse, starts/stops playback
//   codec          pcm_record_buffer_if.slave (record_*, new_frame in; sample_* out)
//   recording      high while in RECORD
//   playing        high while in PLAY
//   length         number of valid stored frames, 0..2^ADDR_WIDTH

module pcm_record_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     record_button,
    input  logic                     play_button,
    pcm_record_buffer_if.slave       codec,
    output logic                     recording,
    output logic                     playing,
    output logic [ADDR_WIDTH:0]      length
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_n;
    logic [ADDR_WIDTH:0]   rd_ptr, rd_ptr_n;
    logic [ADDR_WIDTH:0]   len, len_n;
    logic [31:0]           sample, sample_n;
    logic                  we;
    logic [31:0]           rdata;

    logic [31:0] mem [DEPTH];

    // Storage word layout: {left, right}.
    // The read port is addressed with the next pointer so rdata always equals
    // mem[rd_ptr] in the current cycle. This keeps back-to-back new_frame
    // pulses correct: after an increment, the following cycle already sees
    // the new frame instead of the one just consumed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {codec.record_left, codec.record_right};
        end
        rdata <= mem[rd_ptr_n[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            sample <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            len    <= len_n;
            sample <= sample_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        len_n    = len;
        sample_n = sample;
        we       = 1'b0;

        case (state)
            IDLE: begin
                sample_n = '0;
                // Record has priority when both buttons pulse together.
                if (record_button) begin
                    state_n  = RECORD;
                    wr_ptr_n = '0;
                    len_n    = '0;
                end else if (play_button && (len != '0)) begin
                    state_n  = PLAY;
                    rd_ptr_n = '0;
                end
            end

            RECORD: begin
                // A frame arriving with the stop pulse is still kept.
                if (codec.record_valid) begin
                    we       = 1'b1;
                    wr_ptr_n = wr_ptr + PTR_ONE;
                    len_n    = len + PTR_ONE;
                    if (wr_ptr == PTR_LAST) begin
                        state_n = IDLE;
                    end
                end
                if (record_button) begin
                    state_n = IDLE;
                end
            end

            PLAY: begin
                // The stop button beats a simultaneous new_frame.
                if (play_button) begin
                    sample_n = '0;
                    state_n  = IDLE;
                end else if (codec.new_frame) begin
                    if (rd_ptr < len) begin
                        sample_n = rdata;
                        rd_ptr_n = rd_ptr + PTR_ONE;
                    end else begin
                        // One frame period after the last stored frame.
                        sample_n = '0;
                        state_n  = IDLE;
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                sample_n = '0;
            end
        endcase
    end

    assign recording          = (state == RECORD);
    assign playing            = (state == PLAY);
    assign length             = len;
    assign codec.sample_left  = sample[31:16];
    assign codec.sample_right = sample[15:0];

endmodule

// File: tb/tb_pcm_record_buffer.sv
// tb/tb_pcm_record_buffer.sv - self-checking bench for pcm_record_buffer

module tb_pcm_record_buffer;

    localparam int AW  = 3;
    localparam int DEP = 1 << AW;
    localparam int GAP = 50;

    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_PLAY = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          record_button;
    logic          play_button;
    logic          recording;
    logic          playing;
    logic [AW:0]   length;

    pcm_record_buffer_if bus ();

    pcm_record_buffer #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .record_button (record_button),
        .play_button   (play_button),
        .codec         (bus.slave),
        .recording     (recording),
        .playing       (playing),
        .length        (length)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_st = M_IDLE;
    int          m_len = 0;
    int          m_rd = 0;
    logic [31:0] m_mem [DEP];
    logic [31:0] m_sample = '0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        record_button    = 1'b0;
        play_button      = 1'b0;
        bus.record_valid = 1'b0;
        bus.new_frame    = 1'b0;
        bus.record_left  = '0;
        bus.record_right = '0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_recording"}, 32'(recording), 32'(m_st == M_REC));
        check({tag, "_playing"},   32'(playing),   32'(m_st == M_PLAY));
        check({tag, "_length"},    32'(length),    32'(m_len));
    endtask

    // One clock of stimulus, entered and left at a negedge. Inputs are left
    // asserted so consecutive calls produce back-to-back pulses.
    task automatic cycle(input string tag, input bit rb, input bit pb, input bit rv,
                         input bit nf, input logic [15:0] l, input logic [15:0] r);
        record_button    = rb;
        play_button      = pb;
        bus.record_valid = rv;
        bus.new_frame    = nf;
        bus.record_left  = l;
        bus.record_right = r;
        case (m_st)
            M_IDLE: begin
                m_sample = '0;
                if (rb) begin
                    m_st  = M_REC;
                    m_len = 0;
                end else if (pb && m_len > 0) begin
                    m_st = M_PLAY;
                    m_rd = 0;
                end
            end
            M_REC: begin
                if (rv) begin
                    m_mem[m_len] = {l, r};
                    m_len++;
                    if (m_len == DEP) m_st = M_IDLE;
                end
                if (rb) m_st = M_IDLE;
            end
            default: begin
                if (pb) begin
                    m_sample = '0;
                    m_st     = M_IDLE;
                end else if (nf) begin
                    if (m_rd < m_len) begin
                        m_sample = m_mem[m_rd];
                        m_rd++;
                    end else begin
                        m_sample = '0;
                        m_st     = M_IDLE;
                    end
                end
            end
        endcase
        exp_q.push_back(m_sample);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_sample"}, {bus.sample_left, bus.sample_right}, exp_q.pop_front());
        end
        check_status(tag);
    endtask

    task automatic gap(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
        check("hold_sample", {bus.sample_left, bus.sample_right}, m_sample);
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        reset = 1'b1;
        m_st = M_IDLE; m_len = 0; m_rd = 0; m_sample = '0;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_left"},  32'(bus.sample_left),  32'd0);
        check({tag, "_right"}, 32'(bus.sample_right), 32'd0);
        check_status(tag);
    endtask

    initial begin
        logic [15:0] exp_l;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_left",      32'(bus.sample_left),  32'd0);
        check("rst_right",     32'(bus.sample_right), 32'd0);
        check("rst_recording", 32'(recording),        32'd0);
        check("rst_playing",   32'(playing),          32'd0);
        check("rst_length",    32'(length),           32'd0);

        // 1: play with nothing stored
        cycle("t1_play_empty", 0, 1, 0, 0, 16'h0, 16'h0);
        check("t1_playing", 32'(playing), 32'd0);
        gap(GAP);

        // 2: record five frames then stop
        cycle("t2_start", 1, 0, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        for (int i = 0; i < 5; i++) begin
            cycle("t2_rec", 0, 0, 1, 0, 16'h0100 + 16'(i), 16'hFF00 + 16'(i));
            gap(GAP);
        end
        cycle("t2_stop", 1, 0, 0, 0, 16'h0, 16'h0);
        check("t2_length", 32'(length), 32'd5);
        check("t2_recording_fell", 32'(recording), 32'd0);
        gap(GAP);

        // 3: play back seven pulses; five frames then zero
        cycle("t3_play", 0, 1, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        for (int i = 0; i < 7; i++) begin
            cycle("t3_nf", 0, 0, 0, 1, 16'h0, 16'h0);
            exp_l = (i < 5) ? 16'h0100 + 16'(i) : 16'h0;
            check("t3_left", 32'(bus.sample_left), 32'(exp_l));
            check("t3_playing", 32'(playing), 32'(i < 5));
            gap(GAP);
        end

        // 4: overfill; auto-stop at full, then back-to-back playback
        cycle("t4_start", 1, 0, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        for (int i = 0; i < 10; i++) begin
            cycle("t4_rec", 0, 0, 1, 0, 16'h2000 + 16'(i * 3), 16'hA5A0 ^ 16'(i));
            gap(GAP);
        end
        check("t4_length_full", 32'(length), 32'(DEP));
        check("t4_recording", 32'(recording), 32'd0);
        cycle("t4_play", 0, 1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < DEP + 1; i++) begin
            cycle("t4_nf_b2b", 0, 0, 0, 1, 16'h0, 16'h0);
            if (i == DEP - 1) check("t4_last_left", 32'(bus.sample_left), 32'(16'h2000 + 16'((DEP - 1) * 3)));
        end
        gap(GAP);

        // 5a: record_valid together with stop
        cycle("t5a_start", 1, 0, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        cycle("t5a_rec", 0, 0, 1, 0, 16'h1111, 16'h2222);
        gap(GAP);
        cycle("t5a_rec_stop", 1, 0, 1, 0, 16'h3333, 16'h4444);
        check("t5a_length", 32'(length), 32'd2);
        gap(GAP);

        // 5b: both buttons in IDLE -> record
        cycle("t5b_both", 1, 1, 0, 0, 16'h0, 16'h0);
        check("t5b_recording", 32'(recording), 32'd1);
        gap(GAP);
        for (int i = 0; i < 4; i++) begin
            cycle("t5b_rec", 0, 0, 1, 0, 16'h7000 + 16'(i), 16'h8000 - 16'(i));
            gap(GAP);
        end
        cycle("t5b_stop", 1, 0, 0, 0, 16'h0, 16'h0);
        gap(GAP);

        // 5c: stop during third frame
        cycle("t5c_play", 0, 1, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        for (int i = 0; i < 3; i++) begin
            cycle("t5c_nf", 0, 0, 0, 1, 16'h0, 16'h0);
            gap(GAP);
        end
        cycle("t5c_stop", 0, 1, 0, 0, 16'h0, 16'h0);
        check("t5c_zero", {bus.sample_left, bus.sample_right}, 32'd0);
        check("t5c_playing", 32'(playing), 32'd0);
        gap(GAP);

        // 5d: play_button beats a simultaneous new_frame
        cycle("t5d_play", 0, 1, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        cycle("t5d_nf", 0, 0, 0, 1, 16'h0, 16'h0);
        gap(GAP);
        cycle("t5d_stop_nf", 0, 1, 0, 1, 16'h0, 16'h0);
        check("t5d_zero", {bus.sample_left, bus.sample_right}, 32'd0);
        gap(GAP);

        // 6: reset mid-PLAY and mid-RECORD
        cycle("t6_play", 0, 1, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        cycle("t6_nf", 0, 0, 0, 1, 16'h0, 16'h0);
        gap(GAP);
        do_reset("t6_rst_play");
        cycle("t6_play_after", 0, 1, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        cycle("t6_rec", 1, 0, 0, 0, 16'h0, 16'h0);
        gap(GAP);
        cycle("t6_rec_v", 0, 0, 1, 0, 16'h5555, 16'h6666);
        gap(GAP);
        do_reset("t6_rst_rec");
        cycle("t6_play_after2", 0, 1, 0, 0, 16'h0, 16'h0);
        check("t6_playing", 32'(playing), 32'd0);
        gap(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
